spi_operand_receiver: RTL and testbench
=======================================

Name: spi_operand_receiver

Overview:
- Upstream front end of the operand path: an SPI slave, mode 0, MSB first, with one fixed 8-bit frame per ss_n assertion.
- Each frame carries a 4-bit header and a 4-bit operand; the operand is delivered to the ALU A input with a one-cycle valid strobe.
- In the same frame, the block shifts the registered ALU result and flags back to the Arduino on MISO.
- Includes input synchronisation, frame validation, an inactivity timeout and a saturating error counter.

Parameters:
SYNC_STAGES, 2, synchroniser depth for sclk/mosi/ss_n (minimum 2)
HEADER, 4'hA, required value of frame bits [7:4]
TIMEOUT_CYCLES, 1024, clk cycles allowed between sclk edges inside a frame before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sclk_in  in  1  SPI clock from master, asynchronous
mosi_in  in  1  SPI data from master, asynchronous
ss_n_in  in  1  SPI slave select, active low, asynchronous
tx_data  in  8  readback byte {flags[3:0], result[3:0]}, sampled at frame start
miso_out  out  1  SPI data to master
operand_out  out  4  last accepted operand
operand_valid  out  1  one-cycle pulse on acceptance
frame_err  out  1  one-cycle pulse on any rejected or aborted frame
err_count  out  4  saturating rejected-frame count
busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release):
  - operand_out = 0, operand_valid = 0, frame_err = 0, err_count = 0, miso_out = 0, busy = 0, state = IDLE.
  - Synchroniser flops reset to sclk = 0, mosi = 0, ss_n = 1.
- Edge detection:
  - All SPI inputs pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronised stage against one extra delay flop.
  - Supported sclk frequency is at most clk/8.
- States: IDLE, SHIFT, CHECK, WAIT_SS.
- IDLE:
  - On an ss_n falling edge: go to SHIFT, set bit_cnt = 0, clear the timeout counter, load tx_shift = tx_data, drive miso_out = tx_data[7].
- SHIFT:
  - sclk rising: rx_shift = {rx_shift[6:0], mosi}, bit_cnt += 1, timeout counter cleared.
  - sclk falling: tx_shift shifts left by one, miso_out = new tx_shift[7], timeout counter cleared.
  - 8th rising edge: go to CHECK on the next clk.
  - ss_n rising before the 8th rising edge: short frame. Pulse frame_err, increment err_count, go to IDLE. operand_out is unchanged.
  - Timeout counter reaches TIMEOUT_CYCLES-1: pulse frame_err, increment err_count, go to WAIT_SS.
- CHECK (exactly one cycle):
  - rx_shift[7:4] == HEADER: operand_out <= rx_shift[3:0], operand_valid = 1 for that one cycle.
  - Otherwise: frame_err = 1, err_count increments, operand_out is held.
  - Always go to WAIT_SS.
- Acceptance latency: operand_valid rises exactly 1 clk after the clk in which the 8th synchronised sclk rising edge is detected.
- WAIT_SS:
  - Ignore all sclk/mosi activity.
  - Go to IDLE on the ss_n rising edge, or immediately if ss_n is already high.
  - Extra bits beyond 8 are never shifted in.
- miso_out:
  - Driven 0 whenever state is IDLE.
  - Holds tx_shift[7] otherwise.
- err_count saturates at 15 and is cleared only by rst_n.
- Simultaneous events:
  - ss_n rising in the same clk as the 8th rising edge: the frame is complete and is validated normally.
  - ss_n falling in WAIT_SS is not a frame start. The master must deassert ss_n first.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - The partial frame is discarded with no valid and no error pulse.
- operand_valid and frame_err are mutually exclusive in every cycle.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (IDLE, SHIFT, CHECK, WAIT_SS);
  - FRAME_BITS = 8;
  - the default HEADER constant;
  - the tx byte field layout (flags [7:4], result [3:0]).
- One sub-module, spi_input_sync: a SYNC_STAGES-deep synchroniser plus edge detector. Instantiated per input, it outputs the level, a rise pulse and a fall pulse.

Test Plan:
- Reset: hold rst_n low mid-clock -> all outputs 0 and err_count = 0 immediately, before any clk edge.
- Good frame: tx_data = 8'h3C, master sends 8'hA5 at clk/8 -> operand_out = 4'h5 with a single-cycle operand_valid; master samples 8'h3C on MISO; frame_err stays 0.
- Bad header: frame 8'h55 -> frame_err pulses once, err_count = 1, operand_out keeps its previous value 4'h5, no valid.
- Short frame: ss_n raised after 5 bits -> frame_err and err_count increments. A following good frame 8'hA9 then gives operand_out = 4'h9.
- Timeout: ss_n low, 3 bits, then sclk stalls for 1024 clk -> frame_err, state WAIT_SS. Extra sclk pulses are ignored. ss_n rising -> IDLE.
- Saturation and overrun:
  - 17 bad frames -> err_count = 15.
  - A frame of 10 bits starting 8'hA7 -> operand_out = 4'h7 from the first 8 bits; bits 9-10 are ignored.
  - rst_n asserted at bit 4 -> no valid and no error pulse.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI operand receiver.
//   spi_state_t    : receiver FSM states
//   FRAME_BITS     : fixed frame length in bits
//   DEFAULT_HEADER : default value expected in frame bits [7:4]
//   tx_byte_t      : layout of the readback byte shifted out on MISO
package spi_pkg;

    localparam int         FRAME_BITS     = 8;
    localparam logic [3:0] DEFAULT_HEADER = 4'hA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        WAIT_SS = 2'd3
    } spi_state_t;

    // Readback byte: flags in the upper nibble, ALU result in the lower.
    typedef struct packed {
        logic [3:0] flags;
        logic [3:0] result;
    } tx_byte_t;

    function automatic logic header_ok(input logic [7:0] frame, input logic [3:0] hdr);
        return frame[7:4] == hdr;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: multi-flop synchroniser plus edge detector for one
// asynchronous SPI input.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   level      : synchronised level (last synchroniser stage)
//   rise, fall : one-cycle pulses on synchronised edges
module spi_input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RESET_VAL}};
            dly  <= RESET_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            dly  <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = sync[STAGES-1] & ~dly;
    assign fall  = ~sync[STAGES-1] & dly;

endmodule

// File: rtl/spi_operand_receiver.sv
// spi_operand_receiver: SPI mode-0 slave receiving one 8-bit frame per
// ss_n assertion ({header[3:0], operand[3:0]}, MSB first) while shifting
// the readback byte tx_data out on MISO.
//   clk, rst_n     : system clock, async active-low reset
//   sclk_in        : SPI clock (async)
//   mosi_in        : SPI data in (async)
//   ss_n_in        : slave select, active low (async)
//   tx_data        : readback byte {flags, result}, captured at frame start
//   miso_out       : SPI data out (0 while idle)
//   operand_out    : last accepted operand
//   operand_valid  : one-cycle pulse, coincident with the new operand_out
//   frame_err      : one-cycle pulse on bad header, short frame or timeout
//   err_count      : saturating count of rejected frames
//   busy           : high whenever the FSM is not idle
//   state_dbg      : current FSM state
//
// Handshake: operand_valid is a strobe with no back-pressure; the consumer
// must take operand_out in the cycle operand_valid is high. operand_out
// stays stable until the next accepted frame.
module spi_operand_receiver
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [3:0] HEADER         = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_in,
    input  logic       mosi_in,
    input  logic       ss_n_in,
    input  logic [7:0] tx_data,
    output logic       miso_out,
    output logic [3:0] operand_out,
    output logic       operand_valid,
    output logic       frame_err,
    output logic [3:0] err_count,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int              CNT_W   = $clog2(FRAME_BITS) + 1;
    localparam int              TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);

    // Synchronised inputs
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic ss_level,   ss_rise,   ss_fall;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk_in),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi_in),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(ss_n_in),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    // Only the sclk edges, the mosi level and the ss_n edges/level matter.
    logic unused_sync;
    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    // State
    spi_state_t       state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic [3:0]       operand_n;
    logic             valid_n, err_n;
    logic             last_bit;

    assign last_bit = sclk_rise && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            tmo_cnt       <= '0;
            operand_out   <= '0;
            operand_valid <= 1'b0;
            frame_err     <= 1'b0;
            err_count     <= '0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            rx_shift      <= rx_shift_n;
            tx_shift      <= tx_shift_n;
            tmo_cnt       <= tmo_cnt_n;
            operand_out   <= operand_n;
            operand_valid <= valid_n;
            frame_err     <= err_n;
            if (err_n && (err_count != 4'hF)) begin
                err_count <= err_count + 4'd1;
            end
        end
    end

    // The header decision is made as the FSM enters CHECK so that the
    // registered valid/error pulse and the new operand_out appear together
    // during the single CHECK cycle.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_shift_n = rx_shift;
        tx_shift_n = tx_shift;
        tmo_cnt_n  = tmo_cnt;
        operand_n  = operand_out;
        valid_n    = 1'b0;
        err_n      = 1'b0;

        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_n    = SHIFT;
                    bit_cnt_n  = '0;
                    tmo_cnt_n  = '0;
                    tx_shift_n = tx_data;
                end
            end

            SHIFT: begin
                if (last_bit) begin
                    // Completes the frame even if ss_n rises in the same cycle.
                    rx_shift_n = {rx_shift[6:0], mosi_level};
                    bit_cnt_n  = bit_cnt + CNT_W'(1);
                    tmo_cnt_n  = '0;
                    state_n    = CHECK;
                    if (header_ok(rx_shift_n, HEADER)) begin
                        valid_n   = 1'b1;
                        operand_n = rx_shift_n[3:0];
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (ss_rise) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_n = {rx_shift[6:0], mosi_level};
                    bit_cnt_n  = bit_cnt + CNT_W'(1);
                    tmo_cnt_n  = '0;
                end else if (sclk_fall) begin
                    tx_shift_n = {tx_shift[6:0], 1'b0};
                    tmo_cnt_n  = '0;
                end else if (tmo_cnt == TMO_MAX) begin
                    err_n   = 1'b1;
                    state_n = WAIT_SS;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end

            CHECK: begin
                state_n = WAIT_SS;
            end

            WAIT_SS: begin
                // Level test covers both a rising edge and ss_n already high.
                if (ss_level) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign miso_out  = (state == IDLE) ? 1'b0 : tx_shift[7];
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_operand_receiver.sv
module tb_spi_operand_receiver;
  import spi_pkg::*;

  localparam logic [3:0] HDR = 4'hA;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_in, mosi_in, ss_n_in;
  logic [7:0] tx_data;
  logic       miso_out;
  logic [3:0] operand_out;
  logic       operand_valid, frame_err;
  logic [3:0] err_count;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  spi_operand_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .sclk_in(sclk_in), .mosi_in(mosi_in), .ss_n_in(ss_n_in),
    .tx_data(tx_data), .miso_out(miso_out),
    .operand_out(operand_out), .operand_valid(operand_valid),
    .frame_err(frame_err), .err_count(err_count),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_operand;
  logic [3:0] exp_err;
  int         exp_valid_cnt;
  int         exp_err_cnt;
  int         valid_seen = 0;
  int         err_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: counts pulse cycles and pairs each valid with the model queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (operand_valid === 1'b1) begin
        valid_seen++;
        if (exp_q.size() > 0) check("valid_operand", {28'd0, operand_out}, {28'd0, exp_q.pop_front()});
        else check("unexpected_valid", {31'd0, operand_valid}, 32'd0);
      end
      if (frame_err === 1'b1) err_seen++;
      if (operand_valid === 1'b1 || frame_err === 1'b1)
        check("valid_err_exclusive", {31'd0, operand_valid & frame_err}, 32'd0);
    end
  end

  // Model update for one completed frame, from the frame rules alone.
  task automatic model_frame(input logic [7:0] data, input int nbits);
    if (nbits >= 8 && data[7:4] == HDR) begin
      exp_operand = data[3:0];
      exp_valid_cnt++;
      exp_q.push_back(data[3:0]);
    end else begin
      model_error();
    end
  endtask

  task automatic model_error();
    exp_err_cnt++;
    if (exp_err != 4'hF) exp_err = exp_err + 4'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sclk period at clk/8; MISO sampled just before the rising edge.
  task automatic send_bit(input logic b, output logic m);
    mosi_in = b;
    wait_clks(4);
    m = miso_out;
    sclk_in = 1'b1;
    wait_clks(4);
    sclk_in = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] data, input int nbits, output logic [7:0] rx);
    logic b, m;
    rx = 8'h00;
    ss_n_in = 1'b0;
    wait_clks(4);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 8) ? data[7 - i] : 1'($urandom_range(0, 1));
      send_bit(b, m);
      if (i < 8) rx[7 - i] = m;
    end
    wait_clks(4);
    ss_n_in = 1'b1;
    wait_clks(8);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_operand"}, {28'd0, operand_out}, {28'd0, exp_operand});
    check({tag, "_err_count"}, {28'd0, err_count}, {28'd0, exp_err});
    check({tag, "_valid_pulses"}, valid_seen, exp_valid_cnt);
    check({tag, "_err_pulses"}, err_seen, exp_err_cnt);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input int nbits, input logic [7:0] tx);
    logic [7:0] rx;
    tx_data = tx;
    model_frame(data, nbits);
    spi_frame(data, nbits, rx);
    if (nbits >= 8) check({tag, "_miso"}, {24'd0, rx}, {24'd0, tx});
    check_outputs(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic m;
    logic [7:0] data;
    int nbits, r;

    rst_n = 1'b0;
    sclk_in = 1'b0;
    mosi_in = 1'b0;
    ss_n_in = 1'b1;
    tx_data = 8'h00;
    exp_operand = 4'h0;
    exp_err = 4'h0;
    exp_valid_cnt = 0;
    exp_err_cnt = 0;

    // Reset: outputs must be clear before the first clock edge.
    #2;
    check("rst_operand", {28'd0, operand_out}, 32'd0);
    check("rst_valid", {31'd0, operand_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_count", {28'd0, err_count}, 32'd0);
    check("rst_miso", {31'd0, miso_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);

    // Good frame with readback.
    run_frame("good_a5", 8'hA5, 8, 8'h3C);
    // Bad header.
    run_frame("bad_hdr_55", 8'h55, 8, 8'hC3);
    // Short frame, then a good frame.
    run_frame("short_5", 8'hA3, 5, 8'h81);
    run_frame("good_a9", 8'hA9, 8, 8'h7E);

    // Timeout: 3 bits then sclk stalls.
    tx_data = 8'h5A;
    ss_n_in = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), m);
    model_error();
    wait_clks(1100);
    check("tmo_err_pulses", err_seen, exp_err_cnt);
    check("tmo_err_count", {28'd0, err_count}, {28'd0, exp_err});
    check("tmo_state", {30'd0, state_dbg}, 32'(WAIT_SS));
    check("tmo_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), m);
    wait_clks(4);
    check("tmo_extra_state", {30'd0, state_dbg}, 32'(WAIT_SS));
    check("tmo_extra_valid", valid_seen, exp_valid_cnt);
    ss_n_in = 1'b1;
    wait_clks(8);
    check("tmo_release_state", {30'd0, state_dbg}, 32'(IDLE));
    check_outputs("tmo_release");

    // Saturation: 17 bad frames.
    for (int k = 0; k < 17; k++) begin
      data = {4'h0 + 4'($urandom_range(0, 9)), 4'($urandom_range(0, 15))};
      tx_data = 8'($urandom);
      model_frame(data, 8);
      spi_frame(data, 8, data);
    end
    check_outputs("saturate");
    check("saturate_15", {28'd0, err_count}, 32'd15);

    // Overrun: 10 bits, only the first 8 count.
    run_frame("overrun_a7", 8'hA7, 10, 8'hE1);

    // Randomised frames.
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) nbits = 8;
      else if (r < 8) nbits = $urandom_range(9, 11);
      else nbits = $urandom_range(0, 7);
      data[7:4] = ($urandom_range(0, 9) < 7) ? HDR : 4'($urandom_range(0, 15));
      data[3:0] = 4'($urandom_range(0, 15));
      run_frame("rand", data, nbits, 8'($urandom));
    end

    // Reset in the middle of a frame: no valid, no error, everything clear.
    tx_data = 8'hFF;
    ss_n_in = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), m);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_operand", {28'd0, operand_out}, 32'd0);
    check("midrst_err_count", {28'd0, err_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_miso", {31'd0, miso_out}, 32'd0);
    check("midrst_valid", {31'd0, operand_valid}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    exp_operand = 4'h0;
    exp_err = 4'h0;
    ss_n_in = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
    check_outputs("midrst_after");

    // Good frame after reset.
    run_frame("post_rst", {HDR, 4'($urandom_range(0, 15))}, 8, 8'($urandom));
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
